datapath_p: RTL and testbench

- Parametrised successor to the 8-bit CPU datapath.
- Provides a bus mux, MAR, RIP, RAX and RFL, a general register file of NUM_REGS entries, an internal ALU, and a single-port synchronous RAM.
- New relative to the previous generation: configurable widths and register count, selectable ALU operand registers, RIP auto-increment, flag-conditional branch load of RIP, and RFL readable onto the bus.
- Driven cycle-by-cycle by the control FSM; it has no decode logic of its own.

---
 rtl/datapath_p.sv | 234 +++++++++++++++++++++++
 tb/tb_datapath_p.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_p.sv
// datapath_p: parametrised CPU datapath driven cycle-by-cycle by an external
// control FSM. There is no decode logic here, only the datapath itself.
//
// Ports:
//   i_clk, i_reset         clock; synchronous active-high reset
//   i_data_in              external input word (bus source D_IN)
//   i_select               bus source select (registers, then D_IN, RAX, RAM,
//                          RIP, RIP+1, ZERO, RFL; any other code drives 0)
//   i_load_addr            MAR <= bus
//   i_load_rip             RIP <= bus
//   i_inc_rip              RIP <= RIP + 1
//   i_branch, i_cond       RIP <= bus when the condition holds on RFL
//   i_load_reg             per-register write enables, REG[k] <= bus
//   i_alu_a, i_alu_b       ALU operand register indices
//   i_alu_op, i_alu_signed ALU operation and signedness
//   i_load_alu             RAX <= result (except CMP), RFL <= flags
//   i_write_ram            mem[MAR] <= bus
//   o_ram_out              registered RAM read data, mem[MAR]
//   o_rip                  current RIP
//   o_flags                current RFL
//   o_branch_taken         i_branch and condition true (combinational)

module datapath_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8,
  localparam int SEL_W   = $clog2(NUM_REGS + 7),
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_W-1:0]   i_data_in,
  input  logic [SEL_W-1:0]    i_select,
  input  logic                i_load_addr,
  input  logic                i_load_rip,
  input  logic                i_inc_rip,
  input  logic                i_branch,
  input  logic [2:0]          i_cond,
  input  logic [NUM_REGS-1:0] i_load_reg,
  input  logic [IDX_W-1:0]    i_alu_a,
  input  logic [IDX_W-1:0]    i_alu_b,
  input  logic [3:0]          i_alu_op,
  input  logic                i_alu_signed,
  input  logic                i_load_alu,
  input  logic                i_write_ram,
  output logic [DATA_W-1:0]   o_ram_out,
  output logic [ADDR_W-1:0]   o_rip,
  output logic [DATA_W-1:0]   o_flags,
  output logic                o_branch_taken
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] rip;
  logic [DATA_W-1:0] rax;
  logic [DATA_W-1:0] rfl;
  logic [DATA_W-1:0] ram_out;

  logic [ADDR_W-1:0] rip_p1;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_ov;
  logic              sub_ov;
  logic              a_lt_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_ov;
  logic              alu_valid;
  logic [5:0]        flag_bits;
  logic [DATA_W-1:0] flags_next;
  logic              cond_true;
  logic              branch_taken;

  assign rip_p1 = rip + ADDR_W'(1);

  // Bus mux. Codes below NUM_REGS pick a register; the fixed sources follow.
  always_comb begin
    bus = '0;
    if (int'(i_select) < NUM_REGS) begin
      bus = regs[i_select[IDX_W-1:0]];
    end else begin
      case (int'(i_select) - NUM_REGS)
        0:       bus = i_data_in;
        1:       bus = rax;
        2:       bus = ram_out;
        3:       bus = DATA_W'(rip);
        4:       bus = DATA_W'(rip_p1);
        5:       bus = '0;
        6:       bus = rfl;
        default: bus = '0;
      endcase
    end
  end

  // Operand indices beyond the register count (non power-of-two sizes) read 0.
  assign opa = (int'(i_alu_a) < NUM_REGS) ? regs[i_alu_a] : '0;
  assign opb = (int'(i_alu_b) < NUM_REGS) ? regs[i_alu_b] : '0;

  assign sum    = {1'b0, opa} + {1'b0, opb};
  assign diff   = {1'b0, opa} - {1'b0, opb};
  assign add_ov = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
  assign sub_ov = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);
  assign a_lt_b = i_alu_signed ? ($signed(opa) < $signed(opb)) : (opa < opb);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ov    = 1'b0;
    alu_valid = 1'b1;
    case (i_alu_op)
      OP_ADD: begin
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
        alu_ov    = add_ov;
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff[DATA_W-1:0];
        alu_carry = diff[DATA_W];
        alu_ov    = sub_ov;
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_NOT:  alu_res = ~opa;
      OP_SHL: begin
        alu_res   = {opa[DATA_W-2:0], 1'b0};
        alu_carry = opa[DATA_W-1];
      end
      OP_SHR: begin
        alu_res   = {i_alu_signed & opa[DATA_W-1], opa[DATA_W-1:1]};
        alu_carry = opa[0];
      end
      OP_PASS: alu_res = opa;
      default: alu_valid = 1'b0;
    endcase
  end

  // Unused opcodes clear every flag, including the compare flags.
  always_comb begin
    flag_bits = '0;
    if (alu_valid) begin
      flag_bits = {alu_ov,
                   alu_res == {{(DATA_W-1){1'b0}}, 1'b1},
                   alu_res == '0,
                   a_lt_b,
                   opa == opb,
                   alu_carry};
    end
  end

  assign flags_next = DATA_W'(flag_bits);

  // Conditions look only at the registered RFL, never at a same-cycle ALU load.
  always_comb begin
    cond_true = 1'b0;
    case (i_cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = rfl[1];
      3'd2: cond_true = ~rfl[1];
      3'd3: cond_true = rfl[2];
      3'd4: cond_true = ~rfl[2];
      3'd5: cond_true = rfl[3];
      3'd6: cond_true = rfl[0];
      3'd7: cond_true = rfl[5];
      default: cond_true = 1'b0;
    endcase
  end

  assign branch_taken = i_branch & cond_true;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mar     <= '0;
      rip     <= '0;
      rax     <= '0;
      rfl     <= '0;
      ram_out <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      ram_out <= mem[mar];
      if (i_load_addr) begin
        mar <= bus[ADDR_W-1:0];
      end
      if (i_load_rip) begin
        rip <= bus[ADDR_W-1:0];
      end else if (branch_taken) begin
        rip <= bus[ADDR_W-1:0];
      end else if (i_inc_rip) begin
        rip <= rip_p1;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (i_load_reg[k]) begin
          regs[k] <= bus;
        end
      end
      if (i_load_alu) begin
        if (i_alu_op != OP_CMP) begin
          rax <= alu_res;
        end
        rfl <= flags_next;
      end
    end
  end

  // RAM array has no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (i_write_ram && !i_reset) begin
      mem[mar] <= bus;
    end
  end

  assign o_ram_out      = ram_out;
  assign o_rip          = rip;
  assign o_flags        = rfl;
  assign o_branch_taken = branch_taken;

endmodule

// File: tb/tb_datapath_p.sv
module tb_datapath_p;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 8;
  localparam int SW = $clog2(NR + 7);
  localparam int IW = $clog2(NR);

  localparam int S_DIN  = NR;
  localparam int S_RAX  = NR + 1;
  localparam int S_RAM  = NR + 2;
  localparam int S_RIP1 = NR + 4;
  localparam int S_ZERO = NR + 5;
  localparam int S_RFL  = NR + 6;

  localparam int DW2 = 16;
  localparam int AW2 = 10;
  localparam int NR2 = 16;
  localparam int SW2 = $clog2(NR2 + 7);
  localparam int IW2 = $clog2(NR2);

  logic i_clk = 1'b0;
  logic i_reset;

  logic [DW-1:0] i_data_in;
  logic [SW-1:0] i_select;
  logic          i_load_addr, i_load_rip, i_inc_rip, i_branch;
  logic [2:0]    i_cond;
  logic [NR-1:0] i_load_reg;
  logic [IW-1:0] i_alu_a, i_alu_b;
  logic [3:0]    i_alu_op;
  logic          i_alu_signed, i_load_alu, i_write_ram;
  logic [DW-1:0] o_ram_out;
  logic [AW-1:0] o_rip;
  logic [DW-1:0] o_flags;
  logic          o_branch_taken;

  logic [DW2-1:0] b_data_in;
  logic [SW2-1:0] b_select;
  logic           b_load_addr, b_load_rip, b_inc_rip, b_branch;
  logic [2:0]     b_cond;
  logic [NR2-1:0] b_load_reg;
  logic [IW2-1:0] b_alu_a, b_alu_b;
  logic [3:0]     b_alu_op;
  logic           b_alu_signed, b_load_alu, b_write_ram;
  logic [DW2-1:0] b_ram_out;
  logic [AW2-1:0] b_rip;
  logic [DW2-1:0] b_flags;
  logic           b_branch_taken;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  datapath_p #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data_in(i_data_in), .i_select(i_select),
    .i_load_addr(i_load_addr), .i_load_rip(i_load_rip), .i_inc_rip(i_inc_rip),
    .i_branch(i_branch), .i_cond(i_cond), .i_load_reg(i_load_reg),
    .i_alu_a(i_alu_a), .i_alu_b(i_alu_b), .i_alu_op(i_alu_op),
    .i_alu_signed(i_alu_signed), .i_load_alu(i_load_alu), .i_write_ram(i_write_ram),
    .o_ram_out(o_ram_out), .o_rip(o_rip), .o_flags(o_flags),
    .o_branch_taken(o_branch_taken)
  );

  datapath_p #(.DATA_W(DW2), .ADDR_W(AW2), .NUM_REGS(NR2)) dut_wide (
    .i_clk(i_clk), .i_reset(i_reset), .i_data_in(b_data_in), .i_select(b_select),
    .i_load_addr(b_load_addr), .i_load_rip(b_load_rip), .i_inc_rip(b_inc_rip),
    .i_branch(b_branch), .i_cond(b_cond), .i_load_reg(b_load_reg),
    .i_alu_a(b_alu_a), .i_alu_b(b_alu_b), .i_alu_op(b_alu_op),
    .i_alu_signed(b_alu_signed), .i_load_alu(b_load_alu), .i_write_ram(b_write_ram),
    .o_ram_out(b_ram_out), .o_rip(b_rip), .o_flags(b_flags),
    .o_branch_taken(b_branch_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_data_in = '0; i_select = SW'(S_ZERO); i_load_addr = 0; i_load_rip = 0;
    i_inc_rip = 0; i_branch = 0; i_cond = '0; i_load_reg = '0; i_alu_a = '0;
    i_alu_b = '0; i_alu_op = '0; i_alu_signed = 0; i_load_alu = 0; i_write_ram = 0;
  endtask

  task automatic idle_b();
    b_data_in = '0; b_select = SW2'(NR2 + 5); b_load_addr = 0; b_load_rip = 0;
    b_inc_rip = 0; b_branch = 0; b_cond = '0; b_load_reg = '0; b_alu_a = '0;
    b_alu_b = '0; b_alu_op = '0; b_alu_signed = 0; b_load_alu = 0; b_write_ram = 0;
  endtask

  task automatic put_reg(input int k, input logic [DW-1:0] val);
    idle(); i_select = SW'(S_DIN); i_data_in = val; i_load_reg = NR'(1) << k;
    tick(); idle();
  endtask

  task automatic rip_from(input int sel);
    idle(); i_select = SW'(sel); i_load_rip = 1; tick(); idle();
  endtask

  task automatic set_mar(input logic [DW-1:0] a);
    idle(); i_select = SW'(S_DIN); i_data_in = a; i_load_addr = 1; tick(); idle();
  endtask

  task automatic alu_run(input string tag, input logic [3:0] op, input logic sgn,
                         input int a, input int b,
                         input logic [DW-1:0] exp_rax, input logic [DW-1:0] exp_fl);
    idle(); i_alu_op = op; i_alu_signed = sgn; i_alu_a = IW'(a); i_alu_b = IW'(b);
    i_load_alu = 1; tick(); idle();
    chk({tag, "_flags"}, 32'(o_flags), 32'(exp_fl));
    rip_from(S_RAX);
    chk({tag, "_rax"}, 32'(o_rip), 32'(exp_rax));
  endtask

  logic [7:0] br_exp;

  initial begin
    idle(); idle_b();
    i_reset = 1;
    tick(); tick();
    chk("rst_rip", 32'(o_rip), 32'h0);
    chk("rst_flags", 32'(o_flags), 32'h0);
    chk("rst_ram_out", 32'(o_ram_out), 32'h0);
    chk("rst_taken", 32'(o_branch_taken), 32'h0);
    chk("rst_wide_rip", 32'(b_rip), 32'h0);
    i_reset = 0;

    // RIP <= RIP+1 through the bus, full wrap
    idle(); i_select = SW'(S_RIP1); i_load_rip = 1;
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("rip_count", 32'(o_rip), 32'((i + 1) % 256));
    end
    idle();

    // RAM write, 2-edge read latency, read-before-write
    set_mar(8'h11);
    i_select = SW'(S_DIN); i_data_in = 8'h3C; i_write_ram = 1; tick(); idle();
    set_mar(8'h10);
    i_select = SW'(S_DIN); i_data_in = 8'hA5; i_write_ram = 1; tick(); idle();
    set_mar(8'h11);
    set_mar(8'h10);
    chk("ram_edge1_old", 32'(o_ram_out), 32'h3C);
    tick();
    chk("ram_edge2_new", 32'(o_ram_out), 32'hA5);
    i_select = SW'(S_DIN); i_data_in = 8'h5A; i_write_ram = 1; tick(); idle();
    chk("ram_rbw_old", 32'(o_ram_out), 32'hA5);
    tick();
    chk("ram_rbw_new", 32'(o_ram_out), 32'h5A);
    rip_from(S_RAM);
    chk("bus_ram_sel", 32'(o_rip), 32'h5A);

    // ALU
    put_reg(0, 8'h7F);
    put_reg(1, 8'h01);
    alu_run("add_s_ovf", 4'd0, 1'b1, 0, 1, 8'h80, 8'h20);
    idle(); i_select = SW'(S_ZERO); i_load_reg = 8'h01; tick(); idle();
    alu_run("sub_u_borrow", 4'd1, 1'b0, 0, 1, 8'hFF, 8'h05);
    put_reg(4, 8'h96);
    put_reg(5, 8'h3C);
    put_reg(6, 8'hFF);
    alu_run("and", 4'd2, 1'b0, 4, 5, 8'h14, 8'h00);
    alu_run("or", 4'd3, 1'b0, 4, 5, 8'hBE, 8'h00);
    alu_run("xor", 4'd4, 1'b0, 4, 5, 8'hAA, 8'h00);
    alu_run("not", 4'd5, 1'b0, 4, 5, 8'h69, 8'h00);
    alu_run("shl", 4'd6, 1'b0, 4, 5, 8'h2C, 8'h01);
    alu_run("shr_s", 4'd7, 1'b1, 4, 5, 8'hCB, 8'h04);
    alu_run("shr_u", 4'd7, 1'b0, 4, 5, 8'h4B, 8'h00);
    alu_run("sub_s_ovf", 4'd1, 1'b1, 4, 5, 8'h5A, 8'h24);
    alu_run("pass", 4'd8, 1'b0, 4, 5, 8'h96, 8'h00);
    alu_run("op12", 4'd12, 1'b0, 4, 5, 8'h00, 8'h00);
    alu_run("add_carry_z", 4'd0, 1'b0, 6, 1, 8'h00, 8'h09);
    alu_run("add_one", 4'd0, 1'b0, 1, 0, 8'h01, 8'h10);
    idle(); i_select = SW'(S_DIN); i_data_in = 8'h05; i_load_reg = 8'h0C; tick(); idle();
    alu_run("cmp_eq", 4'd9, 1'b0, 2, 3, 8'h01, 8'h0A);

    // Condition codes against RFL=0x0A
    br_exp = 8'h33;
    idle(); i_branch = 1;
    for (int c = 0; c < 8; c++) begin
      i_cond = 3'(c);
      #1;
      chk($sformatf("cond%0d", c), 32'(o_branch_taken), 32'(br_exp[c]));
    end
    idle(); #1;
    chk("no_branch_taken", 32'(o_branch_taken), 32'h0);
    rip_from(S_RFL);
    chk("bus_rfl_sel", 32'(o_rip), 32'h0A);

    idle(); i_select = SW'(S_DIN); i_data_in = 8'h40; i_branch = 1; i_cond = 3'd1; #1;
    chk("br_eq_taken", 32'(o_branch_taken), 32'h1);
    tick(); idle();
    chk("br_eq_rip", 32'(o_rip), 32'h40);
    i_select = SW'(S_DIN); i_data_in = 8'h90; i_branch = 1; i_cond = 3'd2; i_inc_rip = 1; #1;
    chk("br_ne_untaken", 32'(o_branch_taken), 32'h0);
    tick(); idle();
    chk("br_ne_inc", 32'(o_rip), 32'h41);

    // RIP priority
    i_select = SW'(S_DIN); i_data_in = 8'h22; i_load_rip = 1; i_branch = 1;
    i_cond = 3'd0; i_inc_rip = 1; tick(); idle();
    chk("prio_load", 32'(o_rip), 32'h22);
    i_select = SW'(S_DIN); i_data_in = 8'h30; i_branch = 1; i_inc_rip = 1; tick(); idle();
    chk("prio_branch", 32'(o_rip), 32'h30);
    i_inc_rip = 1; tick(); idle();
    chk("prio_inc", 32'(o_rip), 32'h31);

    // Coincident loads sample one bus value
    i_select = SW'(S_DIN); i_data_in = 8'h55; i_load_addr = 1; i_load_rip = 1;
    i_load_reg = 8'h80; tick(); idle();
    chk("coinc_rip", 32'(o_rip), 32'h55);
    i_inc_rip = 1; tick(); idle();
    rip_from(7);
    chk("coinc_reg7", 32'(o_rip), 32'h55);
    i_select = SW'(S_DIN); i_data_in = 8'h66; i_write_ram = 1; tick(); idle();
    tick();
    chk("coinc_mar", 32'(o_ram_out), 32'h66);

    // Reset beats every enable
    i_select = SW'(S_DIN); i_data_in = 8'h77; i_load_addr = 1; i_load_rip = 1;
    i_inc_rip = 1; i_branch = 1; i_load_reg = '1; i_load_alu = 1; i_alu_a = IW'(4);
    i_write_ram = 1; i_reset = 1;
    tick();
    i_reset = 0; idle();
    chk("rstmid_rip", 32'(o_rip), 32'h0);
    chk("rstmid_flags", 32'(o_flags), 32'h0);
    chk("rstmid_ram_out", 32'(o_ram_out), 32'h0);
    i_inc_rip = 1; tick(); idle();
    chk("rstmid_inc", 32'(o_rip), 32'h1);
    rip_from(S_RAX);
    chk("rstmid_rax", 32'(o_rip), 32'h0);
    i_inc_rip = 1; tick(); idle();
    rip_from(7);
    chk("rstmid_reg7", 32'(o_rip), 32'h0);
    set_mar(8'h55);
    tick();
    chk("rstmid_no_write", 32'(o_ram_out), 32'h66);

    // Wide instance: 16 regs, 16-bit data, 10-bit address
    b_select = SW2'(16); b_data_in = 16'hBEEF; b_load_reg = 16'h8000; tick(); idle_b();
    b_select = SW2'(15); b_write_ram = 1; tick(); idle_b();
    tick();
    chk("w_reg15", 32'(b_ram_out), 32'hBEEF);
    b_select = SW2'(16); b_data_in = 16'hFFFF; b_load_addr = 1; b_load_rip = 1; tick(); idle_b();
    chk("w_rip_trunc", 32'(b_rip), 32'h3FF);
    b_select = SW2'(16); b_data_in = 16'h1234; b_write_ram = 1; tick(); idle_b();
    tick();
    chk("w_mar_3ff", 32'(b_ram_out), 32'h1234);
    b_alu_a = IW2'(15); b_alu_op = 4'd8; b_load_alu = 1; tick(); idle_b();
    chk("w_pass_flags", 32'(b_flags), 32'h0);
    b_select = SW2'(17); b_write_ram = 1; tick(); idle_b();
    tick();
    chk("w_rax_sel", 32'(b_ram_out), 32'hBEEF);
    b_select = SW2'(20); b_load_rip = 1; tick(); idle_b();
    chk("w_rip1_wrap", 32'(b_rip), 32'h0);
    b_inc_rip = 1; tick(); idle_b();
    chk("w_inc", 32'(b_rip), 32'h1);
    b_select = SW2'(23); b_load_rip = 1; tick(); idle_b();
    chk("w_sel_invalid", 32'(b_rip), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
